grs_latch: RTL and testbench



---
 rtl/grs_latch.sv | 107 ++++++++++
 tb/tb_grs_latch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/grs_latch.sv
// Gated RS latch with registered complementary outputs and a sticky forbidden-input flag.
// Optional build macro GRS_LATCH_SYNC_EN adds 2-flop input synchronizers (latency 3 cycles).
module grs_latch (
  input  logic CLK,
  input  logic RST,
  input  logic ENA,
  input  logic R,
  input  logic S,
  output logic Q,
  output logic Q_L,
  output logic FORBID,
  output logic ERR
);

  typedef enum logic [1:0] {
    RST_ST    = 2'd0,
    SET_ST    = 2'd1,
    FORBID_ST = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   q_q, q_d;
  logic   q_l_q, q_l_d;
  logic   forbid_q, forbid_d;
  logic   ena_s, r_s, s_s;

`ifdef GRS_LATCH_SYNC_EN
  // Each row carries {ENA, R, S}; row 1 is the metastability-safe output.
  logic [1:0][2:0] sync_q, sync_d;

  always_comb begin
    sync_d[0] = {ENA, R, S};
    sync_d[1] = sync_q[0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign {ena_s, r_s, s_s} = sync_q[1];
`else
  assign ena_s = ENA;
  assign r_s   = R;
  assign s_s   = S;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (ena_s && s_s && r_s) begin
      state_d = FORBID_ST;
      err_d   = 1'b1;
    end else if (ena_s && s_s) begin
      state_d = SET_ST;
    end else if (ena_s && r_s) begin
      state_d = RST_ST;
    end else begin
      // Hold, except that the forbidden state always resolves to reset.
      case (state_q)
        SET_ST:  state_d = SET_ST;
        default: state_d = RST_ST;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    q_d      = 1'b0;
    q_l_d    = 1'b1;
    forbid_d = 1'b0;
    case (state_d)
      SET_ST: begin
        q_d   = 1'b1;
        q_l_d = 1'b0;
      end
      FORBID_ST: begin
        q_l_d    = 1'b0;
        forbid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RST_ST;
      err_q    <= 1'b0;
      q_q      <= 1'b0;
      q_l_q    <= 1'b1;
      forbid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      q_q      <= q_d;
      q_l_q    <= q_l_d;
      forbid_q <= forbid_d;
    end
  end

  assign Q      = q_q;
  assign Q_L    = q_l_q;
  assign FORBID = forbid_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_grs_latch.sv
// Self-checking bench for grs_latch: directed vector table, corner sequences, random vs. model.
module tb_grs_latch;
`ifdef GRS_LATCH_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic CLK = 1'b0, RST = 1'b0, ENA = 1'b0, R = 1'b0, S = 1'b0;
  logic Q, Q_L, FORBID, ERR;
  bit   clk_run = 1'b0;
  int   total = 0, bad = 0;

  // Behavioural model: stored bit, forbidden flag, sticky error, input delay line.
  bit   mq, mf, merr;
  bit [2:0] dq[$];

  grs_latch dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .R(R), .S(S),
    .Q(Q), .Q_L(Q_L), .FORBID(FORBID), .ERR(ERR)
  );

  always begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    string nm;
    bit ena, s, r;
    int n;
    bit q, ql, f, e;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input bit q, input bit ql, input bit f, input bit e);
    chk({nm, ".Q"}, Q, q);
    chk({nm, ".Q_L"}, Q_L, ql);
    chk({nm, ".FORBID"}, FORBID, f);
    chk({nm, ".ERR"}, ERR, e);
  endtask

  task automatic chk_model(input string nm);
    chk_all(nm, mq, !mq && !mf, mf, merr);
  endtask

  task automatic reset_model();
    mq = 0; mf = 0; merr = 0;
    dq.delete();
    for (int i = 0; i < LAT - 1; i++) dq.push_back(3'b000);
  endtask

  // One rising edge: the model consumes the inputs present at that edge (delayed by LAT-1).
  task automatic step();
    bit [2:0] eff;
    dq.push_back({ENA, S, R});
    @(posedge CLK);
    eff = dq.pop_front();
    if (eff[2] && eff[1] && eff[0]) begin mq = 0; mf = 1; merr = 1; end
    else if (eff[2] && eff[1])      begin mq = 1; mf = 0; end
    else if (eff[2] && eff[0])      begin mq = 0; mf = 0; end
    else begin
      if (mf) mq = 0;
      mf = 0;
    end
    #1;
  endtask

  initial begin
    vt[0] = '{"set",        1, 1, 0, 1,  1, 0, 0, 0};
    vt[1] = '{"gated_hold", 0, 0, 1, 10, 1, 0, 0, 0};
    vt[2] = '{"reset",      1, 0, 1, 1,  0, 1, 0, 0};
    vt[3] = '{"idle_hold",  1, 0, 0, 10, 0, 1, 0, 0};
    vt[4] = '{"forbid",     1, 1, 1, 1,  0, 0, 1, 1};
    vt[5] = '{"forbid_exit",1, 0, 0, 1,  0, 1, 0, 1};
    vt[6] = '{"set_again",  1, 1, 0, 1,  1, 0, 0, 1};
    vt[7] = '{"forbid2",    1, 1, 1, 1,  0, 0, 1, 1};
    vt[8] = '{"gate_exit",  0, 1, 1, 1,  0, 1, 0, 1};
    vt[9] = '{"gated_set",  0, 1, 0, 3,  0, 1, 0, 1};

    // Asynchronous reset with the clock stopped.
    #3 RST = 1'b1;
    #1 chk_all("rst_async", 0, 1, 0, 0);
    reset_model();
    clk_run = 1'b1;
    @(negedge CLK) RST = 1'b0;
    step();
    chk_model("rst_release");

    for (int v = 0; v < 10; v++) begin
      ENA = vt[v].ena; S = vt[v].s; R = vt[v].r;
      for (int k = 0; k < vt[v].n + LAT - 1; k++) step();
      chk_all(vt[v].nm, vt[v].q, vt[v].ql, vt[v].f, vt[v].e);
    end

    // Asynchronous reset in the middle of the forbidden state.
    ENA = 1; S = 1; R = 1;
    for (int k = 0; k < LAT; k++) step();
    chk("mid.FORBID_pre", FORBID, 1'b1);
    #2 RST = 1'b1;
    #1 chk_all("mid_rst", 0, 1, 0, 0);
    reset_model();
    ENA = 0; S = 0; R = 0;
    @(negedge CLK) RST = 1'b0;
    step();
    chk_model("mid_rst_release");

    // ENA toggles every 19 cycles: set phase then reset phase.
    for (int i = 0; i < 200; i++) begin
      ENA = ((i / 19) % 2) == 0;
      S   = (i < 100);
      R   = (i >= 100);
      step();
      chk_model($sformatf("gate_tog[%0d]", i));
    end

    // Random stimulus, S=R=1 kept fairly rare.
    for (int i = 0; i < 300; i++) begin
      ENA = ($urandom_range(3) != 0);
      S   = $urandom_range(1);
      R   = $urandom_range(1);
      if (S && R && ($urandom_range(2) != 0)) R = 0;
      step();
      chk_model($sformatf("rand[%0d]", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
